// File: rtl/cmd_pkg.sv
// -----------------------------------------------------------------------------
// cmd_pkg
// Shared definitions for the command loaders. It holds the byte offsets of the
// LOAD_INDEX packet fields, the opcode value, the loader state encoding and a
// helper that returns the expected payload length byte.
// -----------------------------------------------------------------------------
package cmd_pkg;

  localparam int B_COUNT = 3;  // record count byte
  localparam int B_START = 4;  // start address, big-endian, bytes 4..5
  localparam int B_PAY   = 6;  // first payload byte

  localparam logic [7:0] OP_LOAD_INDEX = 8'h21;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WRITE = 2'd2
  } load_state_e;

  // Length byte the decoder must report: 5 header bytes plus the payload.
  function automatic logic [15:0] load_len(input logic [7:0] cnt,
                                           input int unsigned bytes_per_rec);
    return 16'd5 + 16'(cnt) * 16'(bytes_per_rec);
  endfunction

endpackage

// File: rtl/idx_rec_extract.sv
// -----------------------------------------------------------------------------
// idx_rec_extract
// Combinational record unpacker. It selects record rec_i from the packet,
// reorders each big-endian index into a little-end-first record word and flags
// whether every index is below vert_limit_i. The vertex loader reuses it.
//
// Ports
//   packet_i      packet bytes, byte k = bits [8k+:8]
//   rec_i         record number
//   vert_limit_i  exclusive upper bound for each index
//   data_o        record, index j at bits [IDX_W*j+:IDX_W]
//   in_range_o    1 when all indices of the record are < vert_limit_i
// -----------------------------------------------------------------------------
module idx_rec_extract
  import cmd_pkg::*;
#(
  parameter  int IDX_W       = 16,
  parameter  int IDX_PER_REC = 3,
  parameter  int PACKET_SIZE = 256,
  localparam int DW          = IDX_W * IDX_PER_REC
) (
  input  logic [8*PACKET_SIZE-1:0] packet_i,
  input  logic [7:0]               rec_i,
  input  logic [15:0]              vert_limit_i,
  output logic [DW-1:0]            data_o,
  output logic                     in_range_o
);

  localparam int IB = IDX_W / 8;
  localparam int CW = (IDX_W > 16) ? IDX_W : 16;

  logic [8*PACKET_SIZE-1:0] shifted;
  logic [IDX_W-1:0]         idx;
  int                       byte_pos;

  // Shifts instead of variable part-selects keep every index width exact.
  // Bytes past the end of the packet shift in as zero.
  always_comb begin
    data_o     = '0;
    in_range_o = 1'b1;
    shifted    = '0;
    idx        = '0;
    byte_pos   = 0;
    for (int j = 0; j < IDX_PER_REC; j++) begin
      idx = '0;
      for (int b = 0; b < IB; b++) begin
        byte_pos = B_PAY + (int'(rec_i) * IDX_PER_REC + j) * IB + b;
        shifted  = packet_i >> (8 * byte_pos);
        idx      = (idx << 8) | IDX_W'(shifted[7:0]);
      end
      data_o = (data_o >> IDX_W) | (DW'(idx) << (DW - IDX_W));
      if (CW'(idx) >= CW'(vert_limit_i)) begin
        in_range_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/cmd_load_index_buf.sv
// -----------------------------------------------------------------------------
// cmd_load_index_buf
// Unpacks a LOAD_INDEX packet into index records and streams them into the
// index RAM through a valid/ready write port.
//
// Ports
//   CLK, rst          clock (rising edge), async active-high reset
//   begin_req_pulse   one-cycle load request
//   begin_len         payload length byte from the decoder
//   begin_packet      command packet
//   vert_limit        live vertex count, latched at accept
//   abort             terminate the current load
//   wr_addr/wr_data   RAM write address / record
//   wr_valid/wr_ready write handshake
//   BUSY              load in progress
//   done              one-cycle pulse on clean completion
//   err_*             sticky error flags, cleared by the next accepted load
//
// state | meaning
// IDLE  | waiting for begin_req_pulse
// CHECK | length/range verdict, record 0 bound check
// WRITE | presenting records, one per handshake
// -----------------------------------------------------------------------------
module cmd_load_index_buf
  import cmd_pkg::*;
#(
  parameter  int DEPTH       = 1024,
  parameter  int IDX_W       = 16,
  parameter  int IDX_PER_REC = 3,
  parameter  int PACKET_SIZE = 256,
  parameter  int WRAP_EN     = 0,
  localparam int AW          = $clog2(DEPTH),
  localparam int DW          = IDX_W * IDX_PER_REC
) (
  input  logic                     CLK,
  input  logic                     rst,
  input  logic                     begin_req_pulse,
  input  logic [7:0]               begin_len,
  input  logic [8*PACKET_SIZE-1:0] begin_packet,
  input  logic [15:0]              vert_limit,
  input  logic                     abort,
  output logic [AW-1:0]            wr_addr,
  output logic [DW-1:0]            wr_data,
  output logic                     wr_valid,
  input  logic                     wr_ready,
  output logic                     BUSY,
  output logic                     done,
  output logic                     err_len,
  output logic                     err_range,
  output logic                     err_index,
  output logic                     err_proto
);

  localparam int IB = IDX_W / 8;

  load_state_e              state_q;
  logic [8*PACKET_SIZE-1:0] pkt_q;
  logic [7:0]               count_q;
  logic [AW-1:0]            start_q;
  logic [15:0]              vlim_q;
  logic [7:0]               rec_q;
  logic [AW-1:0]            wr_addr_q;
  logic [DW-1:0]            wr_data_q;
  logic                     wr_valid_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     err_len_q;
  logic                     err_range_q;
  logic                     err_index_q;
  logic                     err_proto_q;

  logic [7:0]    in_cnt;
  logic [15:0]   in_start;
  logic [16:0]   end_pos;
  logic          len_ok;
  logic          range_ok;
  logic [7:0]    rec_sel;
  logic [DW-1:0] rec_data;
  logic          rec_in_range;
  logic [AW-1:0] addr_inc;
  logic          last_hs;

  assign in_cnt   = begin_packet[8*B_COUNT +: 8];
  assign in_start = {begin_packet[8*B_START +: 8], begin_packet[8*(B_START+1) +: 8]};
  assign end_pos  = 17'(in_start) + 17'(in_cnt);
  assign len_ok   = (16'(begin_len) == load_len(in_cnt, IDX_PER_REC * IB));
  assign range_ok = (WRAP_EN != 0) || (end_pos <= 17'(DEPTH));

  // In CHECK the extractor looks at record 0; in WRITE it looks one record
  // ahead so the next record is verified before it is presented.
  assign rec_sel  = (state_q == WRITE) ? rec_q + 8'd1 : 8'd0;
  assign addr_inc = (wr_addr_q == AW'(DEPTH - 1)) ? '0 : wr_addr_q + 1'b1;
  assign last_hs  = (rec_q == count_q - 8'd1);

  idx_rec_extract #(
    .IDX_W       (IDX_W),
    .IDX_PER_REC (IDX_PER_REC),
    .PACKET_SIZE (PACKET_SIZE)
  ) u_extract (
    .packet_i     (pkt_q),
    .rec_i        (rec_sel),
    .vert_limit_i (vlim_q),
    .data_o       (rec_data),
    .in_range_o   (rec_in_range)
  );

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      pkt_q       <= '0;
      count_q     <= '0;
      start_q     <= '0;
      vlim_q      <= '0;
      rec_q       <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_valid_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_len_q   <= 1'b0;
      err_range_q <= 1'b0;
      err_index_q <= 1'b0;
      err_proto_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (begin_req_pulse) begin
            pkt_q       <= begin_packet;
            count_q     <= in_cnt;
            start_q     <= in_start[AW-1:0];
            vlim_q      <= vert_limit;
            rec_q       <= '0;
            err_len_q   <= !len_ok;
            err_range_q <= !range_ok;
            err_index_q <= 1'b0;
            err_proto_q <= 1'b0;
            busy_q      <= 1'b1;
            // A clean zero-count load completes while CHECK is showing.
            done_q      <= len_ok && range_ok && (in_cnt == 8'd0);
            state_q     <= CHECK;
          end
        end

        CHECK: begin
          if (abort) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            if (begin_req_pulse) err_proto_q <= 1'b1;
            if (err_len_q || err_range_q || (count_q == 8'd0)) begin
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else if (!rec_in_range) begin
              err_index_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= IDLE;
            end else begin
              wr_addr_q  <= start_q;
              wr_data_q  <= rec_data;
              wr_valid_q <= 1'b1;
              rec_q      <= '0;
              state_q    <= WRITE;
            end
          end
        end

        WRITE: begin
          if (abort) begin
            wr_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end else begin
            if (begin_req_pulse) err_proto_q <= 1'b1;
            if (wr_ready) begin
              if (last_hs) begin
                wr_valid_q <= 1'b0;
                busy_q     <= 1'b0;
                done_q     <= 1'b1;
                state_q    <= IDLE;
              end else if (!rec_in_range) begin
                err_index_q <= 1'b1;
                wr_valid_q  <= 1'b0;
                busy_q      <= 1'b0;
                state_q     <= IDLE;
              end else begin
                rec_q     <= rec_q + 8'd1;
                wr_addr_q <= addr_inc;
                wr_data_q <= rec_data;
              end
            end
          end
        end

        default: begin
          wr_valid_q <= 1'b0;
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign wr_valid  = wr_valid_q;
  assign BUSY      = busy_q;
  assign done      = done_q;
  assign err_len   = err_len_q;
  assign err_range = err_range_q;
  assign err_index = err_index_q;
  assign err_proto = err_proto_q;

endmodule

// File: tb/tb_cmd_load_index_buf.sv
// -----------------------------------------------------------------------------
// tb_cmd_load_index_buf
// Directed bench for cmd_load_index_buf. Two instances: u_dut (no wrap) and
// u_wrap (WRAP_EN=1) share every input except the request pulse. Stimulus
// pushes expected writes into per-instance queues; monitors pop and compare on
// every handshake, including the cycle offset from the accept cycle.
// -----------------------------------------------------------------------------
module tb_cmd_load_index_buf;

  localparam int PW = 8 * 256;
  localparam int AW = 10;
  localparam int DW = 48;

  typedef struct {
    int          addr;
    logic [47:0] data;
    int          rel;
  } wr_t;

  logic          CLK = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [7:0]    begin_len = '0;
  logic [PW-1:0] pkt = '0;
  logic [15:0]   vert_limit = '0;
  logic          abort = 1'b0;
  logic          wr_ready = 1'b1;

  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic          v0, v1, busy0, busy1, done0, done1;
  logic [3:0]    err0, err1;

  wr_t q0[$];
  wr_t q1[$];
  int  chk_cnt = 0;
  int  pass_cnt = 0;
  int  cyc = 0;
  int  acc_cyc = 0;
  int  idxv[12];

  cmd_load_index_buf #(.WRAP_EN(0)) u_dut (
    .CLK(CLK), .rst(rst), .begin_req_pulse(req0), .begin_len(begin_len),
    .begin_packet(pkt), .vert_limit(vert_limit), .abort(abort),
    .wr_addr(a0), .wr_data(d0), .wr_valid(v0), .wr_ready(wr_ready),
    .BUSY(busy0), .done(done0), .err_len(err0[3]), .err_range(err0[2]),
    .err_index(err0[1]), .err_proto(err0[0])
  );

  cmd_load_index_buf #(.WRAP_EN(1)) u_wrap (
    .CLK(CLK), .rst(rst), .begin_req_pulse(req1), .begin_len(begin_len),
    .begin_packet(pkt), .vert_limit(vert_limit), .abort(abort),
    .wr_addr(a1), .wr_data(d1), .wr_valid(v1), .wr_ready(wr_ready),
    .BUSY(busy1), .done(done1), .err_len(err1[3]), .err_range(err1[2]),
    .err_index(err1[1]), .err_proto(err1[0])
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [47:0] rec_w(input int i);
    return {16'(idxv[3*i+2]), 16'(idxv[3*i+1]), 16'(idxv[3*i])};
  endfunction

  task automatic build_pkt(input int cnt, input int st);
    pkt = '0;
    pkt |= PW'(cnt & 255) << (8 * 3);
    pkt |= PW'((st >> 8) & 255) << (8 * 4);
    pkt |= PW'(st & 255) << (8 * 5);
    for (int k = 0; k < 12; k++) begin
      pkt |= PW'((idxv[k] >> 8) & 255) << (8 * (6 + 2 * k));
      pkt |= PW'(idxv[k] & 255) << (8 * (7 + 2 * k));
    end
  endtask

  task automatic push_wr(input int d, input int addr, input logic [47:0] data, input int rel);
    wr_t e;
    e.addr = addr; e.data = data; e.rel = rel;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  // Monitors: every handshake must match the head of the expected queue.
  logic          pv_stall = 1'b0;
  logic [AW-1:0] pv_addr;
  logic [DW-1:0] pv_data;

  always @(negedge CLK) begin
    wr_t e;
    if (rst) begin
      pv_stall = 1'b0;
    end else begin
      if (pv_stall) check("stall_hold", {v0, a0, d0}, {1'b1, pv_addr, pv_data});
      pv_stall = v0 && !wr_ready;
      pv_addr  = a0;
      pv_data  = d0;
      if (v0 && wr_ready) begin
        if (q0.size() == 0) begin
          check("unexpected_wr0", 64'(a0), 64'hFFFF);
        end else begin
          e = q0.pop_front();
          check("wr0_addr", 64'(a0), 64'(e.addr));
          check("wr0_data", 64'(d0), 64'(e.data));
          check("wr0_cycle", 64'(cyc - acc_cyc), 64'(e.rel));
        end
      end
    end
  end

  always @(negedge CLK) begin
    wr_t e;
    if (!rst && v1 && wr_ready) begin
      if (q1.size() == 0) begin
        check("unexpected_wr1", 64'(a1), 64'hFFFF);
      end else begin
        e = q1.pop_front();
        check("wr1_addr", 64'(a1), 64'(e.addr));
        check("wr1_data", 64'(d1), 64'(e.data));
        check("wr1_cycle", 64'(cyc - acc_cyc), 64'(e.rel));
      end
    end
  end

  // Issues one load on instance d; returns the cycle of the done pulse and the
  // first cycle with BUSY low (both relative to the accept cycle, -1 if never).
  task automatic do_load(input int d, input int cnt, input int st, input int len,
                         input int vl, input int slo, input int shi, input int r2,
                         input int ab, output int done_rel, output int idle_rel);
    logic bz, dn;
    build_pkt(cnt, st);
    begin_len  = 8'(len);
    vert_limit = 16'(vl);
    done_rel   = -1;
    idle_rel   = -1;
    acc_cyc    = cyc;
    wr_ready   = !(slo <= 0 && shi >= 0);
    abort      = (ab == 0);
    if (d == 0) req0 = 1'b1; else req1 = 1'b1;
    for (int rel = 1; rel <= 60; rel++) begin
      @(posedge CLK); #1;
      req0 = 1'b0; req1 = 1'b0;
      wr_ready = !(rel >= slo && rel <= shi);
      abort    = (rel == ab);
      if (rel == r2) begin
        if (d == 0) req0 = 1'b1; else req1 = 1'b1;
      end
      @(negedge CLK);
      bz = (d == 0) ? busy0 : busy1;
      dn = (d == 0) ? done0 : done1;
      if (rel == 1) check("busy_cycle1", 64'(bz), 64'd1);
      if (dn && done_rel < 0) done_rel = rel;
      if (!bz) begin
        idle_rel = rel;
        break;
      end
    end
    if (idle_rel < 0) check("load_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
    req0 = 1'b0; req1 = 1'b0; abort = 1'b0; wr_ready = 1'b1;
  endtask

  task automatic finish_load(input string name, input int d, input int done_rel,
                             input int exp_done, input logic [3:0] exp_err);
    check({name, "_done"}, 64'(done_rel), 64'(exp_done));
    check({name, "_err"}, 64'((d == 0) ? err0 : err1), 64'(exp_err));
    check({name, "_q_empty"}, 64'((d == 0) ? q0.size() : q1.size()), 64'd0);
    q0.delete();
    q1.delete();
  endtask

  initial begin
    #300_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dr, ir;
    #2;
    check("reset_ctl", {v0, busy0, done0, err0, a0}, 0);
    check("reset_data", 64'(d0), 0);
    @(posedge CLK); #1 rst = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Nominal: two records at 10, 11 in cycles 2 and 3, done in cycle 4.
    idxv = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0};
    push_wr(0, 10, 48'h0003_0002_0001, 2);
    push_wr(0, 11, 48'h0006_0005_0004, 3);
    do_load(0, 2, 10, 17, 100, 99, 99, -1, -1, dr, ir);
    finish_load("nominal", 0, dr, 4, 4'b0000);

    // Back-pressure in cycles 2-4: handshakes in 5 and 6, done in 7.
    push_wr(0, 10, 48'h0003_0002_0001, 5);
    push_wr(0, 11, 48'h0006_0005_0004, 6);
    do_load(0, 2, 10, 17, 100, 2, 4, -1, -1, dr, ir);
    finish_load("stall", 0, dr, 7, 4'b0000);

    // Top of the RAM without wrap: 1022, 1023 pass.
    idxv = '{7, 8, 9, 10, 11, 12, 0, 0, 0, 0, 0, 0};
    push_wr(0, 1022, rec_w(0), 2);
    push_wr(0, 1023, rec_w(1), 3);
    do_load(0, 2, 1022, 17, 100, 99, 99, -1, -1, dr, ir);
    finish_load("edge1022", 0, dr, 4, 4'b0000);

    // 1023 + 2 overflows without wrap.
    do_load(0, 2, 1023, 17, 100, 99, 99, -1, -1, dr, ir);
    finish_load("range", 0, dr, -1, 4'b0100);

    // Same load on the wrapping instance: 1023 then 0.
    push_wr(1, 1023, rec_w(0), 2);
    push_wr(1, 0, rec_w(1), 3);
    do_load(1, 2, 1023, 17, 100, 99, 99, -1, -1, dr, ir);
    finish_load("wrap", 1, dr, 4, 4'b0000);

    // Length 16 for two records (needs 17).
    do_load(0, 2, 10, 16, 100, 99, 99, -1, -1, dr, ir);
    finish_load("len", 0, dr, -1, 4'b1000);

    // Zero count: done in cycle 1, BUSY low in cycle 2.
    do_load(0, 0, 10, 5, 100, 99, 99, -1, -1, dr, ir);
    check("zero_idle", 64'(ir), 64'd2);
    finish_load("zero", 0, dr, 1, 4'b0000);

    // Record 1 holds index 5 with vert_limit 5.
    idxv = '{1, 2, 3, 4, 5, 0, 0, 0, 0, 0, 0, 0};
    push_wr(0, 20, 48'h0003_0002_0001, 2);
    do_load(0, 2, 20, 17, 5, 99, 99, -1, -1, dr, ir);
    check("index_idle", 64'(ir), 64'd3);
    finish_load("index", 0, dr, -1, 4'b0010);

    // Second request in cycle 2: flagged, load still completes.
    idxv = '{1, 2, 3, 4, 5, 6, 0, 0, 0, 0, 0, 0};
    push_wr(0, 10, 48'h0003_0002_0001, 2);
    push_wr(0, 11, 48'h0006_0005_0004, 3);
    do_load(0, 2, 10, 17, 100, 99, 99, 2, -1, dr, ir);
    finish_load("proto", 0, dr, 4, 4'b0001);

    // Abort in cycle 3 of a four-record load: the cycle-3 handshake counts.
    idxv = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12};
    push_wr(0, 100, rec_w(0), 2);
    push_wr(0, 101, rec_w(1), 3);
    do_load(0, 4, 100, 29, 100, 99, 99, -1, 3, dr, ir);
    check("abort_idle", 64'(ir), 64'd4);
    finish_load("abort", 0, dr, -1, 4'b0000);

    // Reset in the middle of WRITE: outputs drop without a clock edge.
    build_pkt(4, 200);
    begin_len  = 8'd29;
    vert_limit = 16'd100;
    push_wr(0, 200, rec_w(0), 2);
    acc_cyc = cyc;
    req0 = 1'b1;
    @(posedge CLK); #1 req0 = 1'b0;
    @(posedge CLK);
    @(posedge CLK); #2;
    check("pre_rst_valid", 64'(v0), 64'd1);
    rst = 1'b1;
    #1;
    check("midrst_ctl", {v0, busy0, done0, err0, a0}, 0);
    check("midrst_data", 64'(d0), 0);
    @(posedge CLK); #1 rst = 1'b0;
    check("midrst_q_empty", 64'(q0.size()), 64'd0);
    repeat (2) @(posedge CLK);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/cmd_load_index_buf.md
Name: cmd_load_index_buf

Overview:
- Generalised successor to the edge-buffer command loader.
- Unpacks a LOAD_INDEX command packet into fixed-width index records and writes them sequentially into an index/edge RAM through a valid/ready write port.
- Adds the following over the previous generation:
  - configurable index width and indices per record
  - write back-pressure
  - per-index bound check against the live vertex count
  - optional address wrap
  - well-defined zero-count completion and an abort input
- Sits between the command decoder and the primitive-assembly index RAM.

Parameters:
- DEPTH, 1024, index RAM entries; AW = $clog2(DEPTH).
- IDX_W, 16, bits per index; must be a multiple of 8; IB = IDX_W/8 bytes per index, big-endian in the packet.
- IDX_PER_REC, 3, indices per record; DW = IDX_W*IDX_PER_REC.
- PACKET_SIZE, 256, packet bus width in bytes.
- WRAP_EN, 0, 1 = start+count overflow wraps modulo DEPTH; 0 = overflow is err_range.

Ports:
- CLK  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- begin_req_pulse  in  1  one-cycle load request.
- begin_len  in  8  payload length byte from the decoder.
- begin_packet  in  8*PACKET_SIZE  packet; byte k = bits [8k+:8].
- vert_limit  in  16  current vertex count; an index must be < vert_limit. Latched at accept.
- abort  in  1  terminate the current load.
- wr_addr  out  AW  RAM write address.
- wr_data  out  DW  record; index j occupies bits [IDX_W*j+:IDX_W].
- wr_valid  out  1  write request.
- wr_ready  in  1  RAM accepts the write when wr_valid && wr_ready.
- BUSY  out  1  load in progress.
- done  out  1  one-cycle pulse when a load finishes cleanly.
- err_len, err_range, err_index, err_proto  out  1 each  sticky error flags.

Behaviour:
- Reset (async, rst=1): every output 0, state IDLE. Internal counters and the latched packet are cleared.
- Packet layout:
  - byte 3 = count
  - bytes 4..5 = start, big-endian
  - payload starts at byte 6
  - record i, index j sits at byte 6 + (i*IDX_PER_REC + j)*IB
- Accept: begin_req_pulse=1 in IDLE (this is cycle 0). The block:
  - latches packet, count, start[AW-1:0] and vert_limit
  - clears err_len, err_range, err_index, err_proto
  - sets BUSY=1 and moves to CHECK.
- Length rule: begin_len == 5 + count*IDX_PER_REC*IB, evaluated in ≥12-bit arithmetic; if it fails, err_len=1.
- Range rule: start + count ≤ DEPTH, evaluated in 17-bit arithmetic. It is skipped when WRAP_EN=1; if it fails, err_range=1.
- CHECK (cycle 1):
  - Any length or range error → IDLE, BUSY=0, no writes, no done pulse.
  - count==0 → done=1 for one cycle, BUSY=0, IDLE.
  - Otherwise → WRITE.
- WRITE:
  - On entry (cycle 2) present record 0 with wr_valid=1 and wr_addr=start.
  - On each handshake, present the next record in the following cycle at addr+1 (modulo DEPTH).
  - Throughput is 1 record/cycle while wr_ready=1.
  - While wr_valid && !wr_ready, wr_addr and wr_data hold stable.
- Index check: each record is checked before it is presented.
  - If any index ≥ latched vert_limit, that record is not presented.
  - The block sets err_index=1, drops wr_valid, clears BUSY and goes to IDLE.
  - Records already written stay in the RAM.
- Completion: on the handshake of record count-1, wr_valid=0, BUSY=0 and done=1 in the next cycle, then IDLE.
- abort=1 in CHECK or WRITE:
  - wr_valid=0 and BUSY=0 in the next cycle; no done pulse.
  - A handshake in the abort cycle itself counts as written.
- Protocol error: begin_req_pulse while BUSY sets err_proto=1; the request is ignored and the current load continues. If begin_req_pulse and abort arrive together, the abort wins and the request is dropped.
- rst mid-load: immediate return to reset values; a pending write is lost.
- Counters: the record counter is 8 bits and never wraps, since count ≤ 255.

Decomposition:
- Shared package cmd_pkg holds the B_COUNT=3, B_START=4 and B_PAY=6 byte offsets, the opcode constant and the state encoding (IDLE, CHECK, WRITE).
- One sub-module, idx_rec_extract: a combinational mux that takes the packet and record number and returns DW-bit data plus an in_range flag against vert_limit. It is reused by the vertex loader.

Test Plan:
- Nominal load, wr_ready=1: count=2, start=10, begin_len=17, indices {1,2,3},{4,5,6}, vert_limit=100 → writes at addr 10 and 11 in cycles 2 and 3; data 0x0003_0002_0001 then 0x0006_0005_0004; done in cycle 4.
- Back-pressure: same load with wr_ready low for cycles 2–4 → addr 10 and its data stay stable while stalled; exactly 2 handshakes; done one cycle after the last handshake.
- Boundary and wrap:
  - start=1022, count=2, WRAP_EN=0 → passes; writes at 1022 and 1023.
  - start=1023, count=2, WRAP_EN=0 → err_range, no writes.
  - start=1023, count=2, WRAP_EN=1 → writes at 1023 and 0.
- Length and zero count:
  - begin_len=16 with count=2 → err_len, no writes.
  - count=0 with begin_len=5 → done in cycle 1, no writes, BUSY low by cycle 2.
- Index violation: vert_limit=5, record 1 holds index 5 → record 0 written, err_index=1, no write for record 1, no done.
- Protocol and abort:
  - second begin_req_pulse during WRITE → err_proto=1 and the load completes normally.
  - abort asserted in cycle 3 of a count=4 load → ≤2 writes, BUSY=0 the next cycle, no done.
  - async rst pulse mid-WRITE → all outputs 0 immediately.
